// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
//   arb_state_e          : arbiter FSM states
//   ARB_TIMEOUT_DEFAULT  : default bus-access timeout in cycles (0 disables it)
//   ARB_CNT_W_DEFAULT    : default wait-counter width (2**W must exceed the timeout)
//   ARB_FMT_WORD         : format code driven on the bus for instruction fetches
package pipeline_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_DM_BUSY = 2'd1,
    ARB_IF_BUSY = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;
  localparam int unsigned ARB_CNT_W_DEFAULT   = 7;

  // Fetches are always full words.
  localparam logic [2:0] ARB_FMT_WORD = 3'b010;

endpackage

// File: rtl/wait_counter.sv
// Bus-access wait counter with terminal-count detect.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clear_i  : restart the count at zero (has priority over enable_i)
//   enable_i : count one more waited cycle
//   tc_o     : count has reached TIMEOUT-1; never asserted when TIMEOUT is 0
module wait_counter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TIMEOUT != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/pipeline_memory_arbiter.sv
// Arbitrates one single-ported, variable-latency memory bus between instruction fetch (IF) and
// data access (MEM stage). Data requests win; a redirect (if_flush) cancels a pending or
// in-flight fetch; each access is bounded by a timeout that forces completion with bus_error.
//   clock, reset          : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (held until if_ready) and address
//   if_flush              : redirect, cancels the pending or in-flight fetch
//   if_rdata/if_ready     : fetched word and 1-cycle completion pulse
//   dm_read_enable/dm_write_enable/dm_addr/dm_wdata/dm_format : data request (held until dm_ready)
//   dm_rdata/dm_ready     : load data and 1-cycle completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata/bus_format : registered bus request
//   bus_rdata/bus_ack     : bus response
//   bus_error             : 1-cycle pulse on a timed-out access
//   mem_stall             : freeze request to pipeline control
module pipeline_memory_arbiter
  import pipeline_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = ARB_CNT_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read_enable,
  input  logic        dm_write_enable,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_format,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_format,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_error,
  output logic        mem_stall
);

  arb_state_e  state_d, state_q;
  logic        flush_d, flush_q;
  logic        bus_we_d, bus_we_q;
  logic [31:0] bus_addr_d, bus_addr_q;
  logic [31:0] bus_wdata_d, bus_wdata_q;
  logic [2:0]  bus_format_d, bus_format_q;

  logic dm_req, busy, grant, tc, timeout, done, flushed;
  logic [31:0] rdata_mux;

  assign dm_req  = dm_read_enable | dm_write_enable;
  assign busy    = (state_q != ARB_IDLE);
  // An ack arriving on the terminal count wins over the timeout.
  assign timeout = busy & ~bus_ack & tc;
  assign done    = busy & (bus_ack | timeout);
  // A redirect in the completing cycle also cancels the fetch it targets.
  assign flushed = flush_q | if_flush;

  wait_counter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wait_counter (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (grant),
    .enable_i(busy & ~bus_ack),
    .tc_o    (tc)
  );

  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_format_d = bus_format_q;
    grant        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (dm_req) begin
          state_d      = ARB_DM_BUSY;
          grant        = 1'b1;
          bus_we_d     = dm_write_enable;
          bus_addr_d   = dm_addr;
          bus_wdata_d  = dm_wdata;
          bus_format_d = dm_format;
        end else if (if_req && !if_flush) begin
          state_d      = ARB_IF_BUSY;
          grant        = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = '0;
          bus_format_d = ARB_FMT_WORD;
        end
      end
      ARB_DM_BUSY: begin
        if (done) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IF_BUSY: begin
        if (if_flush) begin
          flush_d = 1'b1;
        end
        if (done) begin
          state_d = ARB_IDLE;
          flush_d = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      flush_q      <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_format_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_format_q <= bus_format_d;
    end
  end

  // Timed-out reads return zero.
  assign rdata_mux  = bus_ack ? bus_rdata : '0;
  assign if_rdata   = rdata_mux;
  assign dm_rdata   = rdata_mux;
  assign if_ready   = (state_q == ARB_IF_BUSY) & done & ~flushed;
  assign dm_ready   = (state_q == ARB_DM_BUSY) & done;
  assign bus_error  = timeout;
  assign bus_req    = busy;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_format = bus_format_q;
  assign mem_stall  = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule
